// File: rtl/foo_intf.sv
// Single-bit FIFO with transfer/drop counters; push visible on a_out one cycle later.
// Moore outputs only: a_in_ready drops when full (no same-cycle slot reuse), refused offers counted.
module foo_intf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_in,
  input  logic                     a_in_valid,
  output logic                     a_in_ready,
  output logic                     a_out,
  output logic                     a_out_valid,
  input  logic                     a_out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xfer_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             push, pop;

  assign a_in_ready  = (level_q < LVL_FULL);
  assign a_out_valid = (level_q != '0);
  assign a_out       = a_out_valid & mem_q[rd_ptr_q];
  assign level       = level_q;
  assign xfer_cnt    = xfer_q;
  assign drop_cnt    = drop_q;

  assign push = a_in_valid & a_in_ready;
  assign pop  = a_out_valid & a_out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    xfer_d   = xfer_q;
    drop_d   = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = a_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      xfer_d   = xfer_q + CNT_ONE;
    end
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
    // Drop counter saturates rather than wrapping so overflow stays visible.
    if (a_in_valid && !a_in_ready && (drop_q != '1)) begin
      drop_d = drop_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      xfer_q   <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      xfer_q   <= xfer_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_foo_intf.sv
// Bench for foo_intf: directed scenarios plus random traffic against a queue-based reference.
module tb_foo_intf;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int CNT_MAX = CNT_MOD - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_in = 1'b0;
  logic             a_in_valid = 1'b0;
  logic             a_in_ready;
  logic             a_out;
  logic             a_out_valid;
  logic             a_out_ready = 1'b0;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, counters as plain integers.
  bit mq[$];
  int m_xfer = 0;
  int m_drop = 0;

  foo_intf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_in        (a_in),
    .a_in_valid  (a_in_valid),
    .a_in_ready  (a_in_ready),
    .a_out       (a_out),
    .a_out_valid (a_out_valid),
    .a_out_ready (a_out_ready),
    .level       (level),
    .xfer_cnt    (xfer_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_out;
    exp_out = (mq.size() > 0) ? mq[0] : 1'b0;
    chk({tag, ".level"},    32'(level),       32'(mq.size()));
    chk({tag, ".in_rdy"},   32'(a_in_ready),  32'(mq.size() < DEPTH));
    chk({tag, ".out_vld"},  32'(a_out_valid), 32'(mq.size() > 0));
    chk({tag, ".a_out"},    32'(a_out),       32'(exp_out));
    chk({tag, ".xfer"},     32'(xfer_cnt),    32'(m_xfer));
    chk({tag, ".drop"},     32'(drop_cnt),    32'(m_drop));
  endtask

  // Drive one cycle's inputs (called away from the rising edge), advance the model, then check.
  task automatic cycle(input bit r, input bit v, input bit d, input bit o, input bit do_chk);
    bit can_push, do_pop;
    rst = r; a_in_valid = v; a_in = d; a_out_ready = o;
    if (r) begin
      mq.delete();
      m_xfer = 0;
      m_drop = 0;
    end else begin
      can_push = (mq.size() < DEPTH);
      do_pop   = (mq.size() > 0) && o;
      if (v && !can_push && m_drop < CNT_MAX) m_drop++;
      if (do_pop) begin
        void'(mq.pop_front());
        m_xfer = (m_xfer + 1) % CNT_MOD;
      end
      if (v && can_push) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    if (do_chk) check_all("cyc");
  endtask

  initial begin
    // Reset state
    cycle(1, 1, 1, 1, 1);
    cycle(1, 0, 0, 0, 1);

    // Fill with 1,0,1,1; stalled consumer
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 0, 1);
    chk("full.level", 32'(level), 32'd4);
    chk("full.a_out", 32'(a_out), 32'd1);

    // a_in_ready must not react to a_out_ready within the cycle
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    #1;
    chk("full.rdy_no_comb", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b0;

    // Three refused offers while full
    for (int i = 0; i < 3; i++) cycle(0, 1, 1'($urandom), 0, 1);
    chk("drop3", 32'(drop_cnt), 32'd3);

    // Drain: expect 1,0,1,1 then empty
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    chk("drain.xfer", 32'(xfer_cnt), 32'd4);
    chk("drain.vld", 32'(a_out_valid), 32'd0);

    // Pop on empty has no effect
    cycle(0, 0, 0, 1, 1);

    // Full plus pop plus offer: pop happens, offer refused
    for (int i = 0; i < 4; i++) cycle(0, 1, 1'(i), 0, 1);
    cycle(0, 1, 1, 1, 1);
    cycle(0, 1, 0, 1, 1);

    // Level 2 steady streaming across pointer wrap
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1'(i), 1, 1);
    chk("stream.level", 32'(level), 32'd2);
    chk("stream.xfer", 32'(xfer_cnt), 32'd10);

    // Reset mid-operation with push and pop offered
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 1);
    cycle(1, 1, 1, 1, 1);
    chk("rst_mid.rdy", 32'(a_in_ready), 32'd1);

    // 256 pops wrap xfer_cnt to 0
    cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 256; i++) cycle(0, 1, 1'($urandom), 1, 0);
    check_all("wrap");
    chk("wrap.xfer", 32'(xfer_cnt), 32'd0);

    // 300 refused offers saturate drop_cnt
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 300; i++) cycle(0, 1, 1'($urandom), 0, 0);
    check_all("sat");
    chk("sat.drop", 32'(drop_cnt), 32'd255);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) != 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/foo_intf.md
FOO_INTF -- requirements
Module: foo_intf

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries holding single-bit "a" values; power of two, at least 2.
REQ-002 Parameter CNT_W, default 8, width of the transfer and drop counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a_in  input  1  producer data bit "a".
REQ-006 a_in_valid  input  1  producer offers a_in this cycle.
REQ-007 a_in_ready  output  1  block can accept a_in this cycle.
REQ-008 a_out  output  1  head-of-FIFO "a" value to consumer.
REQ-009 a_out_valid  output  1  a_out holds a valid entry.
REQ-010 a_out_ready  input  1  consumer takes a_out this cycle.
REQ-011 level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-012 xfer_cnt  output  CNT_W  count of completed consumer transfers.
REQ-013 drop_cnt  output  CNT_W  count of producer offers refused while full.

Function
REQ-014 Push occurs on a clock edge when a_in_valid=1 and a_in_ready=1; a_in is written at the write pointer.
REQ-015 Pop occurs on a clock edge when a_out_valid=1 and a_out_ready=1; the read pointer advances.
REQ-016 a_in_ready SHALL be 1 exactly when level < DEPTH, derived from registered state only (no combinational path from a_out_ready).
REQ-017 a_out_valid SHALL be 1 exactly when level > 0; a_out SHALL equal the head entry when valid and 0 when empty.
REQ-018 First-word latency: a value pushed on edge N is visible on a_out/a_out_valid after edge N, i.e. one cycle; no fall-through within a cycle.
REQ-019 Simultaneous push and pop, neither full nor empty: both occur, level unchanged, ordering preserved.
REQ-020 When full, a_in_ready=0 even if a pop occurs the same cycle; the freed slot becomes available the next cycle.
REQ-021 When empty, a_out_ready has no effect; level, pointers and xfer_cnt are unchanged.
REQ-022 Pointers wrap modulo DEPTH; data order is strictly FIFO across wrap.
REQ-023 level increments on push-only, decrements on pop-only, and never exceeds DEPTH or goes below 0.
REQ-024 xfer_cnt increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
REQ-025 drop_cnt increments by 1 each cycle with a_in_valid=1 and a_in_ready=0, saturating at 2^CNT_W-1.
REQ-026 All outputs are functions of registered state only (Moore style).

Reset
REQ-027 While rst=1 at a rising edge: level=0, pointers=0, xfer_cnt=0, drop_cnt=0, storage cleared to 0; inputs are ignored that cycle.
REQ-028 Outputs after reset: a_in_ready=1, a_out_valid=0, a_out=0, level=0, xfer_cnt=0, drop_cnt=0.
REQ-029 Reset asserted mid-operation discards all stored entries; a push and a pop presented in the reset cycle do not take effect.

Verification
REQ-030 Reset, then push 1,0,1,1 on four consecutive cycles with a_out_ready=0 -> level=4, a_in_ready=0, a_out=1, a_out_valid=1.
REQ-031 From full, hold a_in_valid=1 for 3 cycles with a_out_ready=0 -> drop_cnt=3, level=4, contents unchanged.
REQ-032 From full, a_out_ready=1 for 4 cycles -> a_out sequence 1,0,1,1; xfer_cnt=4; level=0; a_out_valid=0, a_out=0.
REQ-033 Level 2, simultaneous push and pop for 10 cycles with alternating data -> level stays 2, output order matches input order across pointer wrap, xfer_cnt=10.
REQ-034 Push 3 entries, assert rst one cycle with a_in_valid=1 and a_out_ready=1 -> level=0, xfer_cnt=0, drop_cnt=0, a_out_valid=0, a_in_ready=1.
REQ-035 Perform 256 pops with CNT_W=8 -> xfer_cnt=0; 300 refused offers -> drop_cnt=255.
